// File: rtl/fb_swap_ctrl_if.sv
// ---------------------------------------------------------------------------
// fb_swap_ctrl_if
// Bundles the timing-generator inputs, the renderer handshake and the
// display-side outputs of the framebuffer swap controller.
//   Timing in : hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in
//   Renderer  : render_req_in, render_done_in -> render_grant_out, wr_buf_out
//   Display   : rd_buf_out, rd_addr_out, hs_out, vs_out, ad_out
//   Status    : swap_out, dropped_out
// The slave modport is the controller; master is the surrounding system.
// ---------------------------------------------------------------------------
interface fb_swap_ctrl_if #(
  parameter int HC_W   = 11,
  parameter int VC_W   = 10,
  parameter int ADDR_W = 20,
  parameter int DROP_W = 16
);
  logic [HC_W-1:0]   hcount_in;
  logic [VC_W-1:0]   vcount_in;
  logic              hs_in;
  logic              vs_in;
  logic              ad_in;
  logic              nf_in;
  logic              render_req_in;
  logic              render_grant_out;
  logic              render_done_in;
  logic              wr_buf_out;
  logic              rd_buf_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic              hs_out;
  logic              vs_out;
  logic              ad_out;
  logic              swap_out;
  logic [DROP_W-1:0] dropped_out;

  modport slave (
    input  hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in,
    input  render_req_in, render_done_in,
    output render_grant_out, wr_buf_out, rd_buf_out, rd_addr_out,
    output hs_out, vs_out, ad_out, swap_out, dropped_out
  );

  modport master (
    output hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in,
    output render_req_in, render_done_in,
    input  render_grant_out, wr_buf_out, rd_buf_out, rd_addr_out,
    input  hs_out, vs_out, ad_out, swap_out, dropped_out
  );
endinterface

// File: rtl/fb_swap_ctrl.sv
// ---------------------------------------------------------------------------
// fb_swap_ctrl
// Double-buffered framebuffer controller. Produces the front-buffer read
// address from the video timing counts, delays hs/vs/ad by 1+READ_LATENCY
// cycles so they line up with BRAM read data, and hands the back buffer to
// the renderer via req/grant/done. Buffers swap only on the new-frame strobe
// after a completed render; frames shown again are counted (saturating).
// Ports:
//   pixel_clk_in : pixel clock
//   rst_in       : synchronous active-high reset
//   bus          : fb_swap_ctrl_if.slave (timing in, renderer handshake,
//                  display outputs, status)
// ---------------------------------------------------------------------------
module fb_swap_ctrl #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int LINE_WIDTH      = 1650,
  parameter int FRAME_HEIGHT    = 750,
  parameter int READ_LATENCY    = 2,
  parameter int DROP_W          = 16
) (
  input  logic           pixel_clk_in,
  input  logic           rst_in,
  fb_swap_ctrl_if.slave  bus
);

  localparam int ADDR_W = $clog2(ACTIVE_H_PIXELS * ACTIVE_LINES);
  localparam int HC_W   = $clog2(LINE_WIDTH);
  localparam int VC_W   = $clog2(FRAME_HEIGHT);
  localparam int DLY    = 1 + READ_LATENCY;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RENDERING = 2'd1,
    READY     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_nxt;
  logic              w_swap;
  logic              w_drop;

  logic              r_grant;
  logic              r_swap;
  logic              r_rd_buf;
  logic [DROP_W-1:0] r_dropped;

  logic [HC_W-1:0]   w_hc;
  logic [VC_W-1:0]   w_vc;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr_p0;
  logic [2:0]        r_strb_p [DLY];

  // Buffer FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = 1'b0;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.render_req_in) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = RENDERING;
        end
        // Nothing is ready to show, so the current front frame repeats.
        if (bus.nf_in) w_drop = 1'b1;
      end
      RENDERING: begin
        // A render finishing on the very nf cycle still makes this frame.
        if (bus.render_done_in && bus.nf_in) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.render_done_in) begin
          w_state_nxt = READY;
        end else if (bus.nf_in) begin
          w_drop = 1'b1;
        end
      end
      READY: begin
        if (bus.nf_in) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_grant   <= 1'b0;
      r_swap    <= 1'b0;
      r_rd_buf  <= 1'b0;
      r_dropped <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_swap  <= w_swap;
      if (w_swap) r_rd_buf <= ~r_rd_buf;
      if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + DROP_W'(1);
    end
  end

  assign w_hc   = bus.hcount_in;
  assign w_vc   = bus.vcount_in;
  assign w_addr = ADDR_W'(w_vc) * ADDR_W'(ACTIVE_H_PIXELS) + ADDR_W'(w_hc);

  // Stage p0: registered read address
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) r_addr_p0 <= '0;
    else        r_addr_p0 <= bus.ad_in ? w_addr : '0;
  end

  // Stages p0..p(DLY-1): {hs,vs,ad} delay line matching address + BRAM latency
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DLY; i++) r_strb_p[i] <= 3'b000;
    end else begin
      r_strb_p[0] <= {bus.hs_in, bus.vs_in, bus.ad_in};
      for (int i = 1; i < DLY; i++) r_strb_p[i] <= r_strb_p[i-1];
    end
  end

  assign bus.render_grant_out = r_grant;
  assign bus.swap_out         = r_swap;
  assign bus.rd_buf_out       = r_rd_buf;
  assign bus.wr_buf_out       = ~r_rd_buf;
  assign bus.dropped_out      = r_dropped;
  assign bus.rd_addr_out      = r_addr_p0;
  assign bus.hs_out           = r_strb_p[DLY-1][2];
  assign bus.vs_out           = r_strb_p[DLY-1][1];
  assign bus.ad_out           = r_strb_p[DLY-1][0];

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: 8x4 active area, READ_LATENCY=2, 3-bit drop counter.
module tb_fb_swap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_swap_ctrl_if #(.HC_W(4), .VC_W(3), .ADDR_W(5), .DROP_W(3)) bus ();

  fb_swap_ctrl #(
    .ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .LINE_WIDTH(12),
    .FRAME_HEIGHT(6), .READ_LATENCY(2), .DROP_W(3)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hc, vc, hs, vs, ad, nf, req, done;
    int grant, swap, rdb, addr, hso, vso, ado, drop;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int hc, input int vc, input int hs, input int vs,
                       input int ad, input int nf, input int req, input int done);
    bus.hcount_in      = 4'(hc);
    bus.vcount_in      = 3'(vc);
    bus.hs_in          = hs[0];
    bus.vs_in          = vs[0];
    bus.ad_in          = ad[0];
    bus.nf_in          = nf[0];
    bus.render_req_in  = req[0];
    bus.render_done_in = done[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply handshake inputs for one cycle, then check control outputs.
  task automatic step(input string nm, input int nf, input int req, input int done,
                      input int grant, input int swap, input int rdb, input int drop);
    drive(0, 0, 0, 0, 0, nf, req, done);
    tick();
    chk({nm, ".grant"}, int'(bus.render_grant_out), grant);
    chk({nm, ".swap"},  int'(bus.swap_out), swap);
    chk({nm, ".rdbuf"}, int'(bus.rd_buf_out), rdb);
    chk({nm, ".wrbuf"}, int'(bus.wr_buf_out), 1 - rdb);
    chk({nm, ".drop"},  int'(bus.dropped_out), drop);
  endtask

  initial begin
    //            hc vc hs vs ad nf rq dn | gr sw rb addr hso vso ado drp
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{3, 2, 0, 0, 1, 0, 0, 0,   0, 0, 0, 19, 0, 0, 0, 0};
    tbl[2]  = '{3, 2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0,  0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0,  0, 0, 0, 0};
    tbl[12] = '{5, 3, 0, 0, 1, 0, 0, 0,   0, 0, 1, 29, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0, 0};

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    chk("rst.rdbuf", int'(bus.rd_buf_out), 0);
    chk("rst.wrbuf", int'(bus.wr_buf_out), 1);
    chk("rst.grant", int'(bus.render_grant_out), 0);
    chk("rst.swap",  int'(bus.swap_out), 0);
    chk("rst.addr",  int'(bus.rd_addr_out), 0);
    chk("rst.strb",  int'({bus.hs_out, bus.vs_out, bus.ad_out}), 0);
    chk("rst.drop",  int'(bus.dropped_out), 0);
    rst = 1'b0;

    // Table: address path, strobe alignment, normal swap
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].hc, tbl[i].vc, tbl[i].hs, tbl[i].vs, tbl[i].ad,
            tbl[i].nf, tbl[i].req, tbl[i].done);
      tick();
      chk($sformatf("v%0d.grant", i), int'(bus.render_grant_out), tbl[i].grant);
      chk($sformatf("v%0d.swap", i),  int'(bus.swap_out), tbl[i].swap);
      chk($sformatf("v%0d.rdbuf", i), int'(bus.rd_buf_out), tbl[i].rdb);
      chk($sformatf("v%0d.wrbuf", i), int'(bus.wr_buf_out), 1 - tbl[i].rdb);
      chk($sformatf("v%0d.addr", i),  int'(bus.rd_addr_out), tbl[i].addr);
      chk($sformatf("v%0d.hso", i),   int'(bus.hs_out), tbl[i].hso);
      chk($sformatf("v%0d.vso", i),   int'(bus.vs_out), tbl[i].vso);
      chk($sformatf("v%0d.ado", i),   int'(bus.ad_out), tbl[i].ado);
      chk($sformatf("v%0d.drop", i),  int'(bus.dropped_out), tbl[i].drop);
    end

    // Late renderer: three frames repeat before done (IDLE, rd_buf=1)
    //       name    nf req dn  gr sw rb drop
    step("late.req",  0, 1, 0,  1, 0, 1, 0);
    step("late.nf1",  1, 0, 0,  0, 0, 1, 1);
    step("late.gap",  0, 0, 0,  0, 0, 1, 1);
    step("late.nf2",  1, 0, 0,  0, 0, 1, 2);
    step("late.nf3",  1, 0, 0,  0, 0, 1, 3);
    step("late.done", 0, 0, 1,  0, 0, 1, 3);
    step("late.swap", 1, 0, 0,  0, 1, 0, 3);
    step("late.idle", 0, 0, 0,  0, 0, 0, 3);

    // done and nf together; req while rendering gets no second grant
    step("sim.req",   0, 1, 0,  1, 0, 0, 3);
    step("sim.gap",   0, 0, 0,  0, 0, 0, 3);
    step("sim.req2",  0, 1, 0,  0, 0, 0, 3);
    step("sim.dnnf",  1, 0, 1,  0, 1, 1, 3);

    // done ignored in IDLE; nf+req in IDLE grants and drops
    step("idl.done",  0, 0, 1,  0, 0, 1, 3);
    step("idl.nf",    1, 0, 0,  0, 0, 1, 4);
    step("idl.nfreq", 1, 1, 0,  1, 0, 1, 5);

    // Reset while RENDERING
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.rdbuf", int'(bus.rd_buf_out), 0);
    chk("mrst.wrbuf", int'(bus.wr_buf_out), 1);
    chk("mrst.grant", int'(bus.render_grant_out), 0);
    chk("mrst.drop",  int'(bus.dropped_out), 0);
    step("mrst.w1",   0, 0, 0,  0, 0, 0, 0);
    step("mrst.w2",   0, 0, 0,  0, 0, 0, 0);
    // Render was abandoned: done is ignored, nf is a drop, not a swap
    step("mrst.done", 0, 0, 1,  0, 0, 0, 0);
    step("mrst.nf",   1, 0, 0,  0, 0, 0, 1);

    // Saturation of the 3-bit drop counter
    for (int k = 2; k <= 7; k++)
      step($sformatf("sat.nf%0d", k), 1, 0, 0, 0, 0, 0, k);
    step("sat.hold1", 1, 0, 0,  0, 0, 0, 7);
    step("sat.hold2", 1, 0, 0,  0, 0, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
